// File: rtl/branch_redirect_unit.sv
// EX-stage branch/jump resolver: redirect, shadow squash, misaligned trap.
// Optional performance counters built only when BRU_PERF_CNT_EN is defined.
module branch_redirect_unit #(
   parameter int unsigned SHADOW_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_ex,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [2:0]  funct3,
   input  logic [31:0] pc_ex,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [31:0] imm,
   input  logic        trap_ack,
   output logic        forward_adr_from_ex,
   output logic [31:0] target_pc,
   output logic [31:0] link_addr,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        trap_misaligned,
   output logic [31:0] trap_pc,
   output logic [31:0] branch_count,
   output logic [31:0] taken_count
);

   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] SHADOW = 2'd1;
   localparam logic [1:0] TRAP   = 2'd2;

   localparam logic [2:0] SHD = 3'(SHADOW_DEPTH);

   logic [1:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        trap_q, trap_d;
   logic [31:0] tpc_q, tpc_d;

   logic        cond;
   logic        jump;
   logic        taken;
   logic        in_run;
   logic        redirect;
   logic        trap_take;
   logic [31:0] jalr_sum;
   logic [31:0] rel_sum;

   always_comb begin
      cond = 1'b0;
      case (funct3)
         3'b000:  cond = (rs1_val == rs2_val);
         3'b001:  cond = (rs1_val != rs2_val);
         3'b100:  cond = ($signed(rs1_val) < $signed(rs2_val));
         3'b101:  cond = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  cond = (rs1_val < rs2_val);
         3'b111:  cond = (rs1_val >= rs2_val);
         default: cond = 1'b0;
      endcase
   end

   assign jalr_sum = rs1_val + imm;
   assign rel_sum  = pc_ex + imm;

   // JALR has priority over JAL/branch when decode bits collide
   assign target_pc = is_jalr ? {jalr_sum[31:1], 1'b0} : rel_sum;
   assign link_addr = pc_ex + 32'd4;

   assign jump  = is_jal | is_jalr;
   assign taken = valid_ex & (jump | (is_branch & cond));

   assign in_run    = (state_q == RUN) & ~rst;
   assign redirect  = in_run & taken & ~target_pc[1];
   assign trap_take = in_run & taken & target_pc[1];

   assign forward_adr_from_ex = redirect;
   assign flush_if_id         = redirect;
   assign flush_id_ex         = redirect;
   assign trap_misaligned     = trap_q;
   assign trap_pc             = tpc_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      trap_d  = trap_q;
      tpc_d   = tpc_q;
      case (state_q)
         RUN: begin
            if (redirect) begin
               cnt_d   = SHD;
               state_d = SHADOW;
            end else if (trap_take) begin
               trap_d  = 1'b1;
               tpc_d   = pc_ex;
               state_d = TRAP;
            end
         end
         SHADOW: begin
            if (cnt_q <= 3'd1) begin
               cnt_d   = 3'd0;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         TRAP: begin
            if (trap_ack) begin
               trap_d  = 1'b0;
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 3'd0;
            trap_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
         trap_q  <= 1'b0;
         tpc_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trap_q  <= trap_d;
         tpc_q   <= tpc_d;
      end
   end

`ifdef BRU_PERF_CNT_EN
   logic [31:0] bc_q, bc_d;
   logic [31:0] tc_q, tc_d;
   logic        evald;

   assign evald = in_run & valid_ex & (jump | is_branch);
   assign bc_d  = bc_q + {31'd0, evald};
   assign tc_d  = tc_q + {31'd0, redirect};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bc_q <= 32'd0;
         tc_q <= 32'd0;
      end else begin
         bc_q <= bc_d;
         tc_q <= tc_d;
      end
   end

   assign branch_count = bc_q;
   assign taken_count  = tc_q;
`else
   assign branch_count = 32'd0;
   assign taken_count  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench for branch_redirect_unit: driver pushes expectations,
// a negedge monitor pops and compares them.
module tb_branch_redirect_unit;

   logic        clk;
   logic        rst;
   logic        valid_ex;
   logic        is_branch;
   logic        is_jal;
   logic        is_jalr;
   logic [2:0]  funct3;
   logic [31:0] pc_ex;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] imm;
   logic        trap_ack;
   logic        forward_adr_from_ex;
   logic [31:0] target_pc;
   logic [31:0] link_addr;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        trap_misaligned;
   logic [31:0] trap_pc;
   logic [31:0] branch_count;
   logic [31:0] taken_count;

   branch_redirect_unit #(.SHADOW_DEPTH(2)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .valid_ex            (valid_ex),
      .is_branch           (is_branch),
      .is_jal              (is_jal),
      .is_jalr             (is_jalr),
      .funct3              (funct3),
      .pc_ex               (pc_ex),
      .rs1_val             (rs1_val),
      .rs2_val             (rs2_val),
      .imm                 (imm),
      .trap_ack            (trap_ack),
      .forward_adr_from_ex (forward_adr_from_ex),
      .target_pc           (target_pc),
      .link_addr           (link_addr),
      .flush_if_id         (flush_if_id),
      .flush_id_ex         (flush_id_ex),
      .trap_misaligned     (trap_misaligned),
      .trap_pc             (trap_pc),
      .branch_count        (branch_count),
      .taken_count         (taken_count)
   );

   typedef struct {
      string       name;
      logic        fwd;
      bit          chk_tgt;
      logic [31:0] tgt;
      bit          chk_link;
      logic [31:0] link;
      logic        trap;
      logic [31:0] tpc;
      logic [31:0] bc;
      logic [31:0] tc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   bc_e     = 0;
   int   tc_e     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "fwd", {31'd0, forward_adr_from_ex}, {31'd0, e.fwd});
            chk(e.name, "flush_if_id", {31'd0, flush_if_id}, {31'd0, e.fwd});
            chk(e.name, "flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e.fwd});
            chk(e.name, "trap", {31'd0, trap_misaligned}, {31'd0, e.trap});
            chk(e.name, "trap_pc", trap_pc, e.tpc);
            chk(e.name, "branch_count", branch_count, e.bc);
            chk(e.name, "taken_count", taken_count, e.tc);
            if (e.chk_tgt) chk(e.name, "target_pc", target_pc, e.tgt);
            if (e.chk_link) chk(e.name, "link_addr", link_addr, e.link);
         end
      end
   end

   task automatic drive(input logic v, input logic br, input logic jl,
                        input logic jr, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im);
      valid_ex  = v;
      is_branch = br;
      is_jal    = jl;
      is_jalr   = jr;
      funct3    = f3;
      pc_ex     = pc;
      rs1_val   = r1;
      rs2_val   = r2;
      imm       = im;
   endtask

   task automatic expect_cyc(input string nm, input logic fwd,
                             input bit ct, input logic [31:0] tgt,
                             input bit cl, input logic [31:0] lnk,
                             input logic trap, input logic [31:0] tpc);
      exp_t e;
      e.name     = nm;
      e.fwd      = fwd;
      e.chk_tgt  = ct;
      e.tgt      = tgt;
      e.chk_link = cl;
      e.link     = lnk;
      e.trap     = trap;
      e.tpc      = tpc;
`ifdef BRU_PERF_CNT_EN
      e.bc = 32'(bc_e);
      e.tc = 32'(tc_e);
`else
      e.bc = 32'd0;
      e.tc = 32'd0;
`endif
      q.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      rst      = 1'b1;
      trap_ack = 1'b0;
      drive(1, 1, 0, 0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20);
      @(posedge clk);
      #1;
      expect_cyc("reset", 0, 1, 32'h120, 0, 0, 0, 0);
      tick();

      rst = 1'b0;
      expect_cyc("beq_taken", 1, 1, 32'h120, 1, 32'h104, 0, 0);
      bc_e++; tc_e++;
      tick();
      drive(1, 1, 0, 0, 3'b000, 32'h104, 32'd5, 32'd5, 32'h20);
      expect_cyc("shadow1", 0, 0, 0, 0, 0, 0, 0);
      tick();
      expect_cyc("shadow2", 0, 0, 0, 0, 0, 0, 0);
      tick();

      drive(1, 1, 0, 0, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
      expect_cyc("bltu_nt", 0, 1, 32'h240, 0, 0, 0, 0);
      bc_e++;
      tick();
      drive(1, 1, 0, 0, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
      expect_cyc("blt_taken", 1, 1, 32'h240, 0, 0, 0, 0);
      bc_e++; tc_e++;
      tick();
      drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
      expect_cyc("idle_sh1", 0, 0, 0, 0, 0, 0, 0);
      tick();
      expect_cyc("idle_sh2", 0, 0, 0, 0, 0, 0, 0);
      tick();

      drive(1, 1, 0, 0, 3'b010, 32'h280, 32'd7, 32'd7, 32'h10);
      expect_cyc("f3_010_nt", 0, 0, 0, 0, 0, 0, 0);
      bc_e++;
      tick();

      drive(1, 0, 0, 1, 3'b000, 32'h300, 32'h203, 32'd0, 32'd0);
      expect_cyc("jalr_misal", 0, 1, 32'h202, 1, 32'h304, 0, 0);
      bc_e++;
      tick();
      drive(1, 0, 1, 0, 3'b000, 32'h400, 32'd0, 32'd0, 32'h10);
      expect_cyc("trap_hold", 0, 0, 0, 0, 0, 1, 32'h300);
      tick();
      trap_ack = 1'b1;
      expect_cyc("trap_ack", 0, 0, 0, 0, 0, 1, 32'h300);
      tick();
      trap_ack = 1'b0;

      drive(1, 0, 1, 0, 3'b000, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8);
      expect_cyc("jal_wrap", 1, 1, 32'h4, 1, 32'h0, 0, 32'h300);
      bc_e++; tc_e++;
      tick();

      rst = 1'b1;
      drive(1, 1, 0, 0, 3'b001, 32'h500, 32'd1, 32'd2, 32'hFFFF_FFF0);
      bc_e = 0; tc_e = 0;
      expect_cyc("rst_in_shadow", 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
      expect_cyc("post_rst_idle", 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 1, 0, 0, 3'b001, 32'h500, 32'd1, 32'd2, 32'hFFFF_FFF0);
      expect_cyc("bne_taken", 1, 1, 32'h4F0, 0, 0, 0, 0);
      bc_e++; tc_e++;
      tick();
      drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
      expect_cyc("bne_sh1", 0, 0, 0, 0, 0, 0, 0);
      tick();
      expect_cyc("bne_sh2", 0, 0, 0, 0, 0, 0, 0);
      tick();

      drive(1, 1, 0, 0, 3'b101, 32'h600, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd8);
      expect_cyc("bge_taken", 1, 1, 32'h608, 0, 0, 0, 0);
      bc_e++; tc_e++;
      tick();
      drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
      expect_cyc("final", 0, 0, 0, 0, 0, 0, 0);
      tick();

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Execute-stage control-transfer resolver for the single-stage/pipelined RV32I core. It consumes the PC and operands of the instruction in EX, decides taken/not-taken for conditional branches, JAL and JALR, and drives the redirect request (`forward_adr_from_ex`, `target_pc`) back to the fetch stage. It also squashes wrong-path shadow instructions, traps misaligned targets, and optionally counts branch events.

## Interface
Parameters:
- `SHADOW_DEPTH`, default 2: cycles after a redirect during which EX inputs are treated as wrong-path; legal range 1..7.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `valid_ex`  in  1  EX holds a real instruction
- `is_branch`, `is_jal`, `is_jalr`  in  1 each  one-hot decode; all zero for non-control instructions
- `funct3`  in  3  branch condition
- `pc_ex`  in  32  PC of the EX instruction
- `rs1_val`, `rs2_val`  in  32  forwarded operands
- `imm`  in  32  sign-extended immediate
- `trap_ack`  in  1  trap handler has taken the trap
- `forward_adr_from_ex`  out  1  redirect fetch this cycle
- `target_pc`  out  32  redirect address
- `link_addr`  out  32  `pc_ex + 4`, for JAL/JALR writeback
- `flush_if_id`, `flush_id_ex`  out  1  kill the two younger pipeline slots
- `trap_misaligned`  out  1  sticky misaligned-target trap
- `trap_pc`  out  32  `pc_ex` of the faulting instruction
- `branch_count`, `taken_count`  out  32  performance counters

## Operation
- Target: branch and JAL use `pc_ex + imm`; JALR uses `(rs1_val + imm) & ~1`. All addition is 32-bit modulo; carry is discarded.
- Branch conditions by `funct3`:
  - `000` BEQ, `001` BNE, `100` BLT (signed), `101` BGE (signed), `110` BLTU, `111` BGEU.
  - `010` and `011` are not taken.
- JAL and JALR are always taken.
- `taken` = `valid_ex` & (`is_jal` | `is_jalr` | (`is_branch` & cond)).
- The FSM has three states:
  - RUN:
    - If `taken` and `target_pc[1]==0`: assert `forward_adr_from_ex`, `flush_if_id` and `flush_id_ex`; load shadow counter with `SHADOW_DEPTH`; go to SHADOW.
    - If `taken` and `target_pc[1]==1`: no redirect and no flush; set `trap_misaligned`; latch `trap_pc<=pc_ex`; go to TRAP.
    - Otherwise stay in RUN.
  - SHADOW: `valid_ex` is ignored (no redirect, no trap, no counting). The counter decrements each cycle. Leave for RUN in the cycle the counter reads 1.
  - TRAP: all EX inputs are ignored. On `trap_ack`, clear `trap_misaligned` and go to RUN. The same instruction is not re-evaluated in that cycle.
- `trap_ack` is ignored outside TRAP.
- Rule for more than one decode bit set: `is_jalr` wins over `is_jal`, which wins over `is_branch`.
- `target_pc` always shows the computed target. It is meaningful only while `forward_adr_from_ex` is high.

## Timing
- `forward_adr_from_ex`, `target_pc`, `link_addr` and the flushes are combinational from the inputs, gated by state. Fetch samples them at the next edge, so the redirect takes effect one cycle after EX resolution.
- Wrong-path instructions fetched in the redirect cycle are removed by the flushes. SHADOW covers any younger valid that leaks through.
- While `rst` is high, and after reset:
  - state = RUN, shadow counter = 0.
  - `trap_misaligned` = 0, `trap_pc` = 0, counters = 0.
  - `forward_adr_from_ex` and both flushes are forced to 0.
- Reset asserted in SHADOW or TRAP returns to RUN immediately and drops any pending trap.
- Redirect latency: 0 cycles to output, 1 cycle to fetch PC. Back-to-back taken instructions are impossible, because the second one falls in SHADOW.

## Configuration
- `BRU_PERF_CNT_EN` defined:
  - `branch_count` increments on every evaluated (RUN-state, `valid_ex`) control instruction.
  - `taken_count` increments on every redirect.
  - Both wrap from 0xFFFFFFFF to 0.
  - Misaligned-trap instructions increment `branch_count` only.
- `BRU_PERF_CNT_EN` undefined: no counter flops are built, and both outputs are tied to 0.

## Test plan
- BEQ taken: `pc_ex=0x100`, `imm=0x20`, `rs1=rs2=5` -> same cycle `forward_adr_from_ex=1`, `target_pc=0x120`, both flushes =1; the next `SHADOW_DEPTH` cycles ignore a BEQ at `pc_ex=0x104`.
- BLT versus BLTU with `rs1=0xFFFFFFFF`, `rs2=1` -> BLT taken, BLTU not taken (`forward_adr_from_ex=0`, no flush).
- JALR with `rs1=0x203`, `imm=0` -> `target_pc=0x202`, so `trap_misaligned=1` and `trap_pc=pc_ex`, with no redirect; inputs are ignored until `trap_ack`, after which the next cycle is back in RUN.
- JAL at `pc_ex=0xFFFFFFFC`, `imm=8` -> `target_pc=0x4` (wrap) and `link_addr=0x0`.
- `rst` pulsed during SHADOW -> outputs 0 immediately; a taken BNE one cycle after release redirects normally.
- With `BRU_PERF_CNT_EN`: 3 branches, 2 of them taken and non-overlapping -> `branch_count=3`, `taken_count=2`. Without the macro, both read 0.
